// File: rtl/cmdq_pkg.sv
// cmdq_pkg: shared definitions for the host command queue.
//   - slot_state_e : per-slot lifecycle encoding (FREE..DONE)
//   - DEF_*        : default geometry of the queue
//   - cmd_width()  : derives the CDB width from word width and row count
package cmdq_pkg;

  typedef enum logic [2:0] {
    ST_FREE       = 3'd0,
    ST_ASSEMBLING = 3'd1,
    ST_PENDING    = 3'd2,
    ST_DISPATCHED = 3'd3,
    ST_DONE       = 3'd4
  } slot_state_e;

  localparam int DEF_WORD_W = 32;
  localparam int DEF_ROWS   = 8;
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_IDX_W  = 3;
  localparam int DEF_ST_W   = 8;

  function automatic int cmd_width(input int word_w, input int rows);
    return word_w * rows;
  endfunction

  localparam int DEF_CMD_W = cmd_width(DEF_WORD_W, DEF_ROWS);

endpackage

// File: rtl/cmdq_index_fifo.sv
// cmdq_index_fifo: synchronous FIFO of slot indices giving dispatch order.
// Ports:
//   clock, reset    : single clock, synchronous active-high reset
//   push, push_data : enqueue a slot index
//   pop             : dequeue the head entry
//   empty           : no entries held
//   head            : index at the front (valid when !empty)
// Pointers carry one extra bit so a full FIFO is distinguishable from empty.
// The engine never holds more than DEPTH pending slots, so no full output.
module cmdq_index_fifo #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [IDX_W-1:0] push_data,
  input  logic             pop,
  output logic             empty,
  output logic [IDX_W-1:0] head
);

  logic [IDX_W-1:0] mem [DEPTH];
  logic [IDX_W:0]   wr_ptr;
  logic [IDX_W:0]   rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign head  = mem[rd_ptr[IDX_W-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[IDX_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/cmdq_engine.sv
// cmdq_engine: multi-slot host command queue.
// Host words are assembled into ROWS-row CDBs held in DEPTH tagged slots,
// dispatched in commit order to the scheduler, marked done by completion
// reports, and freed by host status queries.
// Ports:
//   clock, reset                 : single clock, synchronous active-high reset
//   cmdq_select/cmd_in/cmdq_ready: host word input (row 0 first)
//   cmd_abort                    : discard the partially assembled CDB
//   issued_valid/issued_index    : one-cycle commit notification with slot tag
//   sq_select/sq_ready           : dispatch valid/ready handshake
//   cmd_out/sq_index             : dispatched CDB and its slot tag
//   status_update_enable/cmdq_index/status_in : completion report
//   query_select/query_index/query_release    : status query, optional release
//   query_valid/query_state/query_status      : query response, one cycle later
module cmdq_engine
  import cmdq_pkg::*;
#(
  parameter int WORD_W  = DEF_WORD_W,
  parameter int ROWS    = DEF_ROWS,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int IDX_W   = DEF_IDX_W,
  parameter int ST_W    = DEF_ST_W,
  localparam int CMD_W  = cmd_width(WORD_W, ROWS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmdq_select,
  input  logic [WORD_W-1:0] cmd_in,
  output logic              cmdq_ready,
  input  logic              cmd_abort,
  output logic              issued_valid,
  output logic [IDX_W-1:0]  issued_index,
  output logic              sq_select,
  input  logic              sq_ready,
  output logic [CMD_W-1:0]  cmd_out,
  output logic [IDX_W-1:0]  sq_index,
  input  logic              status_update_enable,
  input  logic [IDX_W-1:0]  cmdq_index,
  input  logic [ST_W-1:0]   status_in,
  input  logic              query_select,
  input  logic [IDX_W-1:0]  query_index,
  input  logic              query_release,
  output logic              query_valid,
  output logic [2:0]        query_state,
  output logic [ST_W-1:0]   query_status
);

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  slot_state_e      slot_state  [DEPTH];
  logic [CMD_W-1:0] slot_data   [DEPTH];
  logic [ST_W-1:0]  slot_status [DEPTH];

  logic [ROW_W-1:0] row_cnt;
  logic [IDX_W-1:0] asm_idx;

  // Lowest-index FREE slot. Uses registered state only, so a slot freed at
  // an edge is not visible here until the following cycle.
  logic             any_free;
  logic [IDX_W-1:0] free_idx;

  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (slot_state[i] == ST_FREE) begin
        any_free = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  assign cmdq_ready = !reset && ((row_cnt != '0) || any_free);

  logic             word_acc;
  logic             abort_hit;
  logic             first_row;
  logic             last_row;
  logic             commit;
  logic [IDX_W-1:0] wr_idx;

  // Abort wins over a word in the same cycle; the word is dropped.
  assign word_acc  = cmdq_select && cmdq_ready && !cmd_abort;
  assign abort_hit = cmd_abort && (row_cnt != '0);
  assign first_row = (row_cnt == '0);
  assign last_row  = (row_cnt == LAST_ROW);
  assign commit    = word_acc && last_row;
  assign wr_idx    = first_row ? free_idx : asm_idx;

  logic             fifo_empty;
  logic [IDX_W-1:0] fifo_head;
  logic             disp_acc;
  logic             disp_load;

  assign disp_acc  = sq_select && sq_ready;
  assign disp_load = !fifo_empty && (!sq_select || sq_ready);

  cmdq_index_fifo #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_order_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (commit),
    .push_data (wr_idx),
    .pop       (disp_load),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  // A slot being accepted by the scheduler is still PENDING, so the state
  // check alone rejects a same-cycle update; the explicit term keeps that
  // intent visible.
  logic upd_hit;
  logic rel_hit;

  assign upd_hit = status_update_enable
                && (slot_state[cmdq_index] == ST_DISPATCHED)
                && !(disp_acc && (sq_index == cmdq_index));
  assign rel_hit = query_select && query_release
                && (slot_state[query_index] == ST_DONE);

  // Slot state and assembly control. Each transition applies to a distinct
  // source state, so at most one of them can target any given slot.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) slot_state[i] <= ST_FREE;
      row_cnt      <= '0;
      asm_idx      <= '0;
      issued_valid <= 1'b0;
      issued_index <= '0;
    end else begin
      issued_valid <= commit;
      if (commit) issued_index <= wr_idx;

      if (abort_hit) begin
        row_cnt             <= '0;
        slot_state[asm_idx] <= ST_FREE;
      end else if (word_acc) begin
        row_cnt <= last_row ? '0 : row_cnt + 1'b1;
        if (first_row) asm_idx <= free_idx;
        if (last_row)
          slot_state[wr_idx] <= ST_PENDING;
        else if (first_row)
          slot_state[wr_idx] <= ST_ASSEMBLING;
      end

      if (disp_acc) slot_state[sq_index]    <= ST_DISPATCHED;
      if (upd_hit)  slot_state[cmdq_index]  <= ST_DONE;
      if (rel_hit)  slot_state[query_index] <= ST_FREE;
    end
  end

  // Payload storage: no reset, validity is tracked by slot_state.
  always_ff @(posedge clock) begin
    if (word_acc) slot_data[wr_idx][int'(row_cnt) * WORD_W +: WORD_W] <= cmd_in;
    if (upd_hit)  slot_status[cmdq_index] <= status_in;
  end

  // Dispatch register stage: loaded from the FIFO head, held while stalled.
  always_ff @(posedge clock) begin
    if (reset) begin
      sq_select <= 1'b0;
      sq_index  <= '0;
      cmd_out   <= '0;
    end else if (disp_load) begin
      sq_select <= 1'b1;
      sq_index  <= fifo_head;
      cmd_out   <= slot_data[fifo_head];
    end else if (disp_acc) begin
      sq_select <= 1'b0;
    end
  end

  // Query response stage: samples state before any same-cycle release.
  always_ff @(posedge clock) begin
    if (reset) begin
      query_valid  <= 1'b0;
      query_state  <= '0;
      query_status <= '0;
    end else begin
      query_valid <= query_select;
      if (query_select) begin
        query_state  <= slot_state[query_index];
        query_status <= (slot_state[query_index] == ST_DONE) ?
                        slot_status[query_index] : '0;
      end
    end
  end

endmodule

// File: tb/tb_cmdq_engine.sv
// tb_cmdq_engine: directed stimulus with a scoreboard; expected commits,
// dispatches, query responses and point probes are queued by the stimulus
// and checked by a separate monitor on the falling clock edge.
module tb_cmdq_engine;

  logic         clock;
  logic         reset;
  logic         cmdq_select;
  logic [31:0]  cmd_in;
  logic         cmdq_ready;
  logic         cmd_abort;
  logic         issued_valid;
  logic [2:0]   issued_index;
  logic         sq_select;
  logic         sq_ready;
  logic [255:0] cmd_out;
  logic [2:0]   sq_index;
  logic         status_update_enable;
  logic [2:0]   cmdq_index;
  logic [7:0]   status_in;
  logic         query_select;
  logic [2:0]   query_index;
  logic         query_release;
  logic         query_valid;
  logic [2:0]   query_state;
  logic [7:0]   query_status;

  cmdq_engine dut (
    .clock                (clock),
    .reset                (reset),
    .cmdq_select          (cmdq_select),
    .cmd_in               (cmd_in),
    .cmdq_ready           (cmdq_ready),
    .cmd_abort            (cmd_abort),
    .issued_valid         (issued_valid),
    .issued_index         (issued_index),
    .sq_select            (sq_select),
    .sq_ready             (sq_ready),
    .cmd_out              (cmd_out),
    .sq_index             (sq_index),
    .status_update_enable (status_update_enable),
    .cmdq_index           (cmdq_index),
    .status_in            (status_in),
    .query_select         (query_select),
    .query_index          (query_index),
    .query_release        (query_release),
    .query_valid          (query_valid),
    .query_state          (query_state),
    .query_status         (query_status)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  localparam int P_READY = 0;
  localparam int P_ZERO  = 1;
  localparam int P_SEL   = 2;
  localparam int P_QV    = 3;
  localparam int P_END   = 4;

  logic [2:0]   exp_issue  [$];
  logic [2:0]   exp_didx   [$];
  logic [255:0] exp_ddata  [$];
  logic [10:0]  exp_query  [$];
  int           probe_kind [$];
  logic         probe_exp  [$];
  string        probe_name [$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: the only process that compares.
  always @(negedge clock) begin
    if (issued_valid) begin
      if (exp_issue.size() == 0) check("unexpected_issue", 1, 0);
      else check("issued_index", issued_index, exp_issue.pop_front());
    end
    if (sq_select) begin
      if (exp_didx.size() == 0) check("unexpected_dispatch", 1, 0);
      else begin
        check("sq_index", sq_index, exp_didx[0]);
        check("cmd_out", cmd_out, exp_ddata[0]);
        if (sq_ready) begin
          void'(exp_didx.pop_front());
          void'(exp_ddata.pop_front());
        end
      end
    end
    if (query_valid) begin
      if (exp_query.size() == 0) check("unexpected_query", 1, 0);
      else check("query_state_status", {query_state, query_status}, exp_query.pop_front());
    end
    while (probe_kind.size() > 0) begin
      int    k;
      logic  e;
      string n;
      k = probe_kind.pop_front();
      e = probe_exp.pop_front();
      n = probe_name.pop_front();
      case (k)
        P_READY: check(n, cmdq_ready, e);
        P_ZERO:  check(n, {cmdq_ready, issued_valid, issued_index, sq_select, sq_index,
                           query_valid, query_state, query_status, |cmd_out}, 0);
        P_SEL:   check(n, sq_select, e);
        P_QV:    check(n, query_valid, e);
        default: check(n, exp_issue.size() + exp_didx.size() + exp_query.size(), 0);
      endcase
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic probe(input int kind, input logic e, input string name);
    probe_kind.push_back(kind);
    probe_exp.push_back(e);
    probe_name.push_back(name);
  endtask

  task automatic idle_inputs();
    cmdq_select = 0; cmd_in = 0; cmd_abort = 0;
    status_update_enable = 0; cmdq_index = 0; status_in = 0;
    query_select = 0; query_index = 0; query_release = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    exp_issue.delete(); exp_didx.delete(); exp_ddata.delete(); exp_query.delete();
    probe(P_ZERO, 0, "reset_outputs_a");
    tick();
    probe(P_ZERO, 0, "reset_outputs_b");
    tick();
    reset = 1'b0;
    probe(P_READY, 1, "ready_after_reset");
    tick();
  endtask

  function automatic logic [255:0] make_cdb(input int k);
    logic [255:0] d;
    for (int r = 0; r < 8; r++) d[r*32 +: 32] = 32'hC0DE0000 | (k << 8) | r;
    return d;
  endfunction

  task automatic send_cdb(input logic [255:0] data, input logic [2:0] idx);
    for (int r = 0; r < 8; r++) begin
      cmdq_select = 1'b1;
      cmd_in = data[r*32 +: 32];
      tick();
    end
    cmdq_select = 1'b0;
    cmd_in = 0;
    exp_issue.push_back(idx);
    exp_didx.push_back(idx);
    exp_ddata.push_back(data);
  endtask

  task automatic query(input logic [2:0] idx, input logic rel, input logic [2:0] st,
                       input logic [7:0] status);
    query_select = 1'b1;
    query_index = idx;
    query_release = rel;
    exp_query.push_back({st, status});
  endtask

  task automatic query_end();
    query_select = 0; query_index = 0; query_release = 0;
  endtask

  initial begin
    logic [255:0] d;
    sq_ready = 1'b0;
    do_reset();

    // Write CDB
    sq_ready = 1'b1;
    d = '0;
    d[31:0]   = 32'h00000040;
    d[127:96] = 32'h01000008;
    send_cdb(d, 3'd0);
    probe(P_SEL, 0, "no_bypass_dispatch");
    tick();
    probe(P_SEL, 1, "dispatch_next_cycle");
    repeat (3) tick();

    // Full queue, stall, then back-to-back drain
    sq_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 8; k++) send_cdb(make_cdb(k), 3'(k));
    probe(P_READY, 0, "full_not_ready");
    cmdq_select = 1'b1; cmd_in = 32'hDEADBEEF;
    tick();
    cmdq_select = 1'b0; cmd_in = 0;
    probe(P_READY, 0, "ninth_word_ignored");
    repeat (3) tick();
    sq_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      probe(P_SEL, 1, "drain_back_to_back");
      tick();
    end
    probe(P_SEL, 0, "drain_done");
    tick();

    // Status update and query
    sq_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 4; k++) send_cdb(make_cdb(10 + k), 3'(k));
    sq_ready = 1'b1;
    repeat (3) tick();
    sq_ready = 1'b0;
    status_update_enable = 1; cmdq_index = 3'd2; status_in = 8'h5A;
    tick();
    cmdq_index = 3'd3; status_in = 8'hA5;
    tick();
    status_update_enable = 0;
    query(3'd2, 0, 3'd4, 8'h5A);
    probe(P_QV, 0, "query_not_same_cycle");
    tick();
    probe(P_QV, 1, "query_one_cycle");
    query(3'd3, 0, 3'd2, 8'h00);
    tick();
    query(3'd0, 0, 3'd3, 8'h00);
    tick();
    query(3'd5, 0, 3'd0, 8'h00);
    tick();
    query_end();
    sq_ready = 1'b1;
    status_update_enable = 1; cmdq_index = 3'd3; status_in = 8'h77;
    tick();
    sq_ready = 1'b0;
    status_update_enable = 0;
    query(3'd3, 0, 3'd3, 8'h00);
    tick();
    query_end();
    tick();

    // Release (slots 0,1,3 dispatched, 2 done)
    for (int k = 4; k < 8; k++) send_cdb(make_cdb(10 + k), 3'(k));
    probe(P_READY, 0, "full_before_release");
    query(3'd1, 1, 3'd3, 8'h00);
    tick();
    query_end();
    probe(P_READY, 0, "release_dispatched_ignored");
    tick();
    query(3'd2, 1, 3'd4, 8'h5A);
    cmdq_select = 1'b1; cmd_in = 32'hBAD0BAD0;
    probe(P_READY, 0, "ready_low_in_release_cycle");
    tick();
    query_end();
    cmdq_select = 1'b0; cmd_in = 0;
    probe(P_READY, 1, "ready_after_release");
    query(3'd2, 0, 3'd0, 8'h00);
    tick();
    query_end();
    send_cdb(make_cdb(20), 3'd2);
    sq_ready = 1'b1;
    repeat (8) tick();

    // Abort
    do_reset();
    for (int r = 0; r < 3; r++) begin
      cmdq_select = 1'b1; cmd_in = 32'h11110000 | r;
      tick();
    end
    cmd_abort = 1'b1; cmd_in = 32'h11110003;
    tick();
    cmd_abort = 1'b0; cmdq_select = 1'b0; cmd_in = 0;
    query(3'd0, 0, 3'd0, 8'h00);
    tick();
    query_end();
    send_cdb(make_cdb(30), 3'd0);
    repeat (3) tick();
    cmd_abort = 1'b1;
    tick();
    cmdq_select = 1'b1; cmd_in = 32'h22222222;
    tick();
    cmd_abort = 1'b0; cmdq_select = 1'b0; cmd_in = 0;
    send_cdb(make_cdb(31), 3'd1);
    repeat (3) tick();

    // Mid-operation reset
    sq_ready = 1'b0;
    do_reset();
    send_cdb(make_cdb(40), 3'd0);
    send_cdb(make_cdb(41), 3'd1);
    for (int r = 0; r < 5; r++) begin
      cmdq_select = 1'b1; cmd_in = 32'h33330000 | r;
      tick();
    end
    cmdq_select = 1'b0; cmd_in = 0;
    do_reset();
    probe(P_SEL, 0, "no_dispatch_after_reset");
    query(3'd0, 0, 3'd0, 8'h00);
    tick();
    query_end();
    sq_ready = 1'b1;
    send_cdb(make_cdb(50), 3'd0);
    repeat (4) tick();

    probe(P_END, 0, "scoreboard_drained");
    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmdq_engine.md
Name: cmdq_engine

Overview:
- Parametrised successor to the single-command interface queue: multi-slot host command queue, one clock.
- Assembles WORD_W-bit host words into ROWS-row command descriptor blocks (CDBs) and stores them in DEPTH tagged slots.
- Dispatches pending CDBs in FIFO order to the scheduler over a valid/ready port, records per-slot completion status, and serves host status queries with explicit slot release.
- Sits between the host command port and the fpga-side scheduler / xfer_buffer control.

Parameters:
- WORD_W, 32, host command word width.
- ROWS, 8, words per CDB. CMD_W = WORD_W*ROWS is a derived localparam (256 at defaults).
- DEPTH, 8, number of command slots; power of two, ≥2.
- IDX_W, 3, slot index width; must equal log2(DEPTH).
- ST_W, 8, status width.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- cmdq_select  in  1  host word valid.
- cmd_in  in  WORD_W  CDB row, row 0 first.
- cmdq_ready  out  1  word accepted when cmdq_select&&cmdq_ready.
- cmd_abort  in  1  discard the partial CDB.
- issued_valid  out  1  one-cycle pulse on CDB commit.
- issued_index  out  IDX_W  tag of the committed slot.
- sq_select  out  1  dispatch valid.
- sq_ready  in  1  scheduler accepts.
- cmd_out  out  CMD_W  dispatched CDB, row 0 in bits [WORD_W-1:0].
- sq_index  out  IDX_W  tag of the dispatched CDB.
- status_update_enable  in  1  completion report.
- cmdq_index  in  IDX_W  slot being reported.
- status_in  in  ST_W  completion status.
- query_select  in  1  status query.
- query_index  in  IDX_W  slot queried.
- query_release  in  1  free the slot if it is DONE; qualified by query_select.
- query_valid  out  1  response valid.
- query_state  out  3  slot state.
- query_status  out  ST_W  stored status.

Behaviour:
- Slot states (3-bit): FREE=0, ASSEMBLING=1, PENDING=2, DISPATCHED=3, DONE=4.
- Reset: all slots FREE; row counter=0; ordering FIFO empty. While reset is high every output is 0, including cmdq_ready.
- cmdq_ready: combinational; =1 when row counter≠0, or when row counter=0 and any slot is FREE.
- Allocation:
  - On the accepted row-0 word, the lowest-index FREE slot becomes ASSEMBLING.
  - Word r is written to bits [r*WORD_W +: WORD_W]; the row counter increments.
- Commit:
  - On the accepted row ROWS-1 word, the slot becomes PENDING at that edge.
  - Its index is pushed to the ordering FIFO.
  - The row counter wraps to 0.
  - issued_valid=1 with issued_index for exactly the next cycle.
- cmd_abort:
  - Row counter←0; the ASSEMBLING slot←FREE; no issued_valid.
  - Abort has priority over a word in the same cycle (that word is dropped).
  - Abort with row counter=0 has no effect.
- Dispatch:
  - sq_select, cmd_out and sq_index are registered from the FIFO head.
  - The earliest assertion is one cycle after the commit edge; there is no same-cycle bypass.
  - Outputs hold stable while sq_select&&!sq_ready.
  - On sq_select&&sq_ready: slot→DISPATCHED, FIFO pops, and the next head may present on the following cycle.
  - Sustained throughput is 1 CDB per cycle while the FIFO is non-empty.
- Status update:
  - Only a DISPATCHED slot→DONE, with status_in stored.
  - An update to any other state is ignored.
  - If an update and a dispatch-accept hit the same slot in the same cycle, the update is ignored.
- Query:
  - One-cycle latency: query_valid, query_state and query_status are valid the cycle after query_select.
  - The response reflects the state before any same-cycle release.
  - query_status reads 0 unless the slot is DONE.
  - query_release on a DONE slot: slot→FREE at that edge. Release on any other state is ignored.
- A slot freed at edge N is allocatable from edge N+1. Same-cycle free-and-allocate never picks it.
- Full queue: with all DEPTH slots non-FREE and row counter=0, cmdq_ready=0; words are ignored.
- Ordering FIFO cannot overflow: there are at most DEPTH PENDING slots.
- Mid-operation reset returns everything to the reset state and discards all slots.

Decomposition:
- Package cmdq_pkg holds:
  - slot-state encodings (FREE..DONE);
  - default WORD_W/ROWS/DEPTH;
  - the CMD_W derivation.
- Sub-module cmdq_index_fifo: synchronous DEPTH×IDX_W FIFO with push, pop, empty and head outputs; wrap-around pointers with an extra bit for full/empty.
- Slot storage, state array, free-slot priority encoder and query logic live in cmdq_engine.

Test Plan:
- Write CDB:
  - Stimulus: after reset, send rows 32'h00000040, 0, 0, 32'h01000008, 0, 0, 0, 0.
  - Required: issued_valid once with index 0; sq_select the cycle after; cmd_out[31:0]=32'h40; cmd_out[127:96]=32'h01000008; sq_index=0.
- Full:
  - Stimulus: commit 8 CDBs with sq_ready=0.
  - Required: indices 0..7 in order; cmdq_ready=0; a 9th word is ignored.
  - Then: sq_ready=1 yields 8 dispatches, sq_index 0..7, cmd_out stable during stall.
- Status:
  - Stimulus: dispatch slot 2; update slot 2 with status_in=8'h5A; query slot 2.
  - Required: query_state=4, query_status=8'h5A.
  - Also: an update to PENDING slot 3 is ignored; querying slot 3 returns state 2, status 0.
- Release:
  - Stimulus: query_release slot 2 while full except slot 2.
  - Required: cmdq_ready rises the next cycle; the new CDB gets index 2; a release on a DISPATCHED slot is ignored.
- Abort:
  - Stimulus: send 3 rows, then cmd_abort together with a 4th word.
  - Required: slot returns FREE; no issued_valid; the next CDB reuses the same index.
- Reset:
  - Stimulus: assert reset after 5 rows of a CDB and with 2 PENDING slots.
  - Required: all outputs 0; after release, the first CDB gets index 0.
